// File: rtl/branch_res_handler_pkg.sv
// Shared types and constants for the branch resolution handler: resolution
// records coming from the branch unit, handler FSM states and BTB update records.
package branch_res_handler_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned BPU_HLEN = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            mispredict;
  } resolution_t;

  typedef enum logic {
    BRH_IDLE,
    BRH_REDIRECT
  } brh_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            del;
  } btb_upd_t;

  // Fall-through address of a branch: the next sequential instruction.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(ILEN >> 3);
  endfunction

endpackage

// File: rtl/branch_res_handler_fifo.sv
// Generic synchronous FIFO with pointer-MSB full/empty detection.
// The head is read combinationally from storage and forced to zero when empty.
module branch_res_handler_fifo #(
  parameter type         DATA_T = logic [7:0],
  parameter int unsigned DEPTH  = 4
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  flush_i,
  input  logic  push_i,
  input  DATA_T data_i,
  input  logic  pop_i,
  output DATA_T data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  DATA_T       r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty_o = (r_wptr == r_rptr);
  // A full buffer refuses pushes even when a pop happens in the same cycle.
  assign w_push  = push_i && !full_o && !flush_i;
  assign w_pop   = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/branch_res_handler.sv
// Consumes branch resolutions: updates PHT/BTB, issues fetch redirects on
// mispredictions and keeps the committed global history register.
module branch_res_handler
  import branch_res_handler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HLEN       = BPU_HLEN
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              bu_res_valid_i,
  output logic              bu_res_ready_o,
  input  resolution_t       bu_res_i,
  output logic              redirect_valid_o,
  input  logic              redirect_ready_i,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              pht_upd_valid_o,
  output logic [XLEN-1:0]   pht_upd_pc_o,
  output logic              pht_upd_taken_o,
  output logic              btb_upd_valid_o,
  output logic              btb_upd_del_o,
  output logic [XLEN-1:0]   btb_upd_pc_o,
  output logic [XLEN-1:0]   btb_upd_target_o,
  output logic              ghr_restore_valid_o,
  output logic [HLEN-1:0]   ghr_o,
  output brh_state_t        dbg_state_o
);

  // Handshakes: a transfer on any valid/ready pair happens in the cycle where
  // both are high; valid never depends combinationally on the matching ready,
  // and redirect_pc_o is held stable while redirect_valid_o waits for ready.

  brh_state_t      r_state;
  brh_state_t      w_next_state;
  logic [HLEN-1:0] r_ghr;
  resolution_t     w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_ghr_upd;
  logic            w_pht_valid;
  logic            w_btb_valid;
  logic            w_ghr_restore;
  logic            w_redirect_valid;
  btb_upd_t        w_btb_upd;

  assign bu_res_ready_o = !w_full;

  branch_res_handler_fifo #(
    .DATA_T (resolution_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .push_i  (bu_res_valid_i),
    .data_i  (bu_res_i),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= BRH_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_pop            = 1'b0;
    w_ghr_upd        = 1'b0;
    w_pht_valid      = 1'b0;
    w_btb_valid      = 1'b0;
    w_btb_upd        = '{pc: w_head.pc, target: w_head.target, del: 1'b0};
    w_ghr_restore    = 1'b0;
    w_redirect_valid = 1'b0;
    case (r_state)
      BRH_IDLE: begin
        if (!w_empty) begin
          if (w_head.mispredict) begin
            w_next_state = BRH_REDIRECT;
          end else begin
            w_pop       = 1'b1;
            w_ghr_upd   = 1'b1;
            w_pht_valid = 1'b1;
            w_btb_valid = w_head.taken;
          end
        end
      end
      BRH_REDIRECT: begin
        w_redirect_valid = 1'b1;
        if (redirect_ready_i) begin
          w_pop         = 1'b1;
          w_ghr_upd     = 1'b1;
          w_pht_valid   = 1'b1;
          w_btb_valid   = 1'b1;
          w_btb_upd.del = !w_head.taken;
          w_ghr_restore = 1'b1;
          w_next_state  = BRH_IDLE;
        end
      end
      default: w_next_state = BRH_IDLE;
    endcase
    // Flush wins over everything, including a coinciding redirect handshake.
    if (flush_i) begin
      w_next_state  = BRH_IDLE;
      w_pop         = 1'b0;
      w_ghr_upd     = 1'b0;
      w_pht_valid   = 1'b0;
      w_btb_valid   = 1'b0;
      w_ghr_restore = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ghr <= '0;
    end else if (w_ghr_upd) begin
      r_ghr <= {r_ghr[HLEN-2:0], w_head.taken};
    end
  end

  assign redirect_valid_o    = w_redirect_valid;
  assign redirect_pc_o       = w_empty ? '0 :
                               (w_head.taken ? w_head.target : next_seq_pc(w_head.pc));
  assign pht_upd_valid_o     = w_pht_valid;
  assign pht_upd_pc_o        = w_head.pc;
  assign pht_upd_taken_o     = w_head.taken;
  assign btb_upd_valid_o     = w_btb_valid;
  assign btb_upd_del_o       = w_btb_upd.del;
  assign btb_upd_pc_o        = w_btb_upd.pc;
  assign btb_upd_target_o    = w_btb_upd.target;
  assign ghr_restore_valid_o = w_ghr_restore;
  assign ghr_o               = r_ghr;
  assign dbg_state_o         = r_state;

endmodule

// File: tb/tb_branch_res_handler.sv
// Testbench for branch_res_handler: directed scenarios plus a randomized run
// against a queue-based reference model of the resolution handler.
module tb_branch_res_handler;
  import branch_res_handler_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HL    = 8;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              flush_i;
  logic              bu_res_valid_i;
  logic              bu_res_ready_o;
  resolution_t       bu_res_i;
  logic              redirect_valid_o;
  logic              redirect_ready_i;
  logic [XLEN-1:0]   redirect_pc_o;
  logic              pht_upd_valid_o;
  logic [XLEN-1:0]   pht_upd_pc_o;
  logic              pht_upd_taken_o;
  logic              btb_upd_valid_o;
  logic              btb_upd_del_o;
  logic [XLEN-1:0]   btb_upd_pc_o;
  logic [XLEN-1:0]   btb_upd_target_o;
  logic              ghr_restore_valid_o;
  logic [HL-1:0]     ghr_o;
  brh_state_t        dbg_state_o;

  int checks   = 0;
  int failures = 0;
  logic [HL-1:0] exp_ghr;

  branch_res_handler #(.FIFO_DEPTH(DEPTH), .HLEN(HL)) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .flush_i             (flush_i),
    .bu_res_valid_i      (bu_res_valid_i),
    .bu_res_ready_o      (bu_res_ready_o),
    .bu_res_i            (bu_res_i),
    .redirect_valid_o    (redirect_valid_o),
    .redirect_ready_i    (redirect_ready_i),
    .redirect_pc_o       (redirect_pc_o),
    .pht_upd_valid_o     (pht_upd_valid_o),
    .pht_upd_pc_o        (pht_upd_pc_o),
    .pht_upd_taken_o     (pht_upd_taken_o),
    .btb_upd_valid_o     (btb_upd_valid_o),
    .btb_upd_del_o       (btb_upd_del_o),
    .btb_upd_pc_o        (btb_upd_pc_o),
    .btb_upd_target_o    (btb_upd_target_o),
    .ghr_restore_valid_o (ghr_restore_valid_o),
    .ghr_o               (ghr_o),
    .dbg_state_o         (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_n_i = 1'b0; flush_i = 1'b0; bu_res_valid_i = 1'b0;
    bu_res_i = '0; redirect_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    exp_ghr = '0;
  endtask

  // ---------------- driver tasks ----------------
  function automatic resolution_t mk(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                                     input logic t, input logic m);
    resolution_t r;
    r.pc = pc; r.target = tgt; r.taken = t; r.mispredict = m;
    return r;
  endfunction

  task automatic drive(input logic v, input resolution_t r, input logic rdy, input logic fl);
    bu_res_valid_i = v; bu_res_i = r; redirect_ready_i = rdy; flush_i = fl;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++; if (bu_res_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bu_res_ready_o); end
    checks++; if (redirect_valid_o !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%0b exp=0", redirect_valid_o); end
    checks++; if ({pht_upd_valid_o, btb_upd_valid_o, ghr_restore_valid_o} !== 3'b000) begin failures++;
      $display("FAIL reset_strobes got=%03b exp=000", {pht_upd_valid_o, btb_upd_valid_o, ghr_restore_valid_o}); end
    checks++; if (ghr_o !== 8'h00) begin failures++; $display("FAIL reset_ghr got=%h exp=00", ghr_o); end
    checks++; if (redirect_pc_o !== '0 || pht_upd_pc_o !== '0) begin failures++;
      $display("FAIL reset_data got=%h/%h exp=0/0", redirect_pc_o, pht_upd_pc_o); end
    checks++; if (dbg_state_o !== BRH_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state_o, BRH_IDLE); end
    next_cycle();
  endtask

  task automatic test_basic();
    drive(1'b1, mk(32'h100, 32'h140, 1'b1, 1'b0), 1'b0, 1'b0);
    @(negedge clk_i);
    checks++; if (pht_upd_valid_o !== 1'b0) begin failures++; $display("FAIL basic_no_bypass got=%0b exp=0", pht_upd_valid_o); end
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++; if (pht_upd_valid_o !== 1'b1 || pht_upd_taken_o !== 1'b1 || pht_upd_pc_o !== 32'h100) begin failures++;
      $display("FAIL basic_pht got=%0b/%0b/%h exp=1/1/100", pht_upd_valid_o, pht_upd_taken_o, pht_upd_pc_o); end
    checks++; if (btb_upd_valid_o !== 1'b1 || btb_upd_del_o !== 1'b0 || btb_upd_pc_o !== 32'h100 || btb_upd_target_o !== 32'h140) begin
      failures++; $display("FAIL basic_btb got=%0b/%0b/%h/%h exp=1/0/100/140", btb_upd_valid_o, btb_upd_del_o, btb_upd_pc_o, btb_upd_target_o); end
    checks++; if (redirect_valid_o !== 1'b0 || ghr_restore_valid_o !== 1'b0) begin failures++;
      $display("FAIL basic_no_redirect got=%0b/%0b exp=0/0", redirect_valid_o, ghr_restore_valid_o); end
    exp_ghr = {exp_ghr[HL-2:0], 1'b1};
    next_cycle();
    @(negedge clk_i);
    checks++; if (ghr_o !== exp_ghr) begin failures++; $display("FAIL basic_ghr got=%h exp=%h", ghr_o, exp_ghr); end
    next_cycle();
  endtask

  task automatic test_mispredict_stall();
    drive(1'b1, mk(32'h200, 32'h300, 1'b0, 1'b1), 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++; if (redirect_valid_o !== 1'b0 || pht_upd_valid_o !== 1'b0 || btb_upd_valid_o !== 1'b0) begin failures++;
      $display("FAIL mis_quiet got=%0b/%0b/%0b exp=0/0/0", redirect_valid_o, pht_upd_valid_o, btb_upd_valid_o); end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h204 || pht_upd_valid_o !== 1'b0) begin failures++;
        $display("FAIL mis_hold%0d got=%0b/%h/%0b exp=1/204/0", i, redirect_valid_o, redirect_pc_o, pht_upd_valid_o); end
      next_cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++; if (pht_upd_valid_o !== 1'b1 || pht_upd_taken_o !== 1'b0 || btb_upd_valid_o !== 1'b1 ||
                  btb_upd_del_o !== 1'b1 || btb_upd_pc_o !== 32'h200) begin failures++;
      $display("FAIL mis_handshake got=%0b/%0b/%0b/%0b/%h exp=1/0/1/1/200", pht_upd_valid_o, pht_upd_taken_o,
               btb_upd_valid_o, btb_upd_del_o, btb_upd_pc_o); end
    checks++; if (ghr_restore_valid_o !== 1'b1 || ghr_o !== exp_ghr) begin failures++;
      $display("FAIL mis_restore got=%0b/%h exp=1/%h", ghr_restore_valid_o, ghr_o, exp_ghr); end
    exp_ghr = {exp_ghr[HL-2:0], 1'b0};
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++; if (redirect_valid_o !== 1'b0 || ghr_o !== exp_ghr) begin failures++;
      $display("FAIL mis_after got=%0b/%h exp=0/%h", redirect_valid_o, ghr_o, exp_ghr); end
    next_cycle();
  endtask

  task automatic test_fill_full();
    resolution_t ent [5];
    ent[0] = mk(32'h400, 32'h500, 1'b1, 1'b1);
    ent[1] = mk(32'h410, 32'h600, 1'b1, 1'b0);
    ent[2] = mk(32'h420, 32'h700, 1'b0, 1'b0);
    ent[3] = mk(32'h430, 32'h800, 1'b1, 1'b0);
    ent[4] = mk(32'h440, 32'h900, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ent[i], 1'b0, 1'b0);
      @(negedge clk_i);
      checks++; if (bu_res_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready%0d got=%0b exp=1", i, bu_res_ready_o); end
      next_cycle();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++; if (bu_res_ready_o !== 1'b0 || redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h500) begin failures++;
      $display("FAIL fill_full got=%0b/%0b/%h exp=0/1/500", bu_res_ready_o, redirect_valid_o, redirect_pc_o); end
    next_cycle();
    // Full buffer pops and sees a valid input in the same cycle.
    drive(1'b1, ent[4], 1'b1, 1'b0);
    @(negedge clk_i);
    checks++; if (bu_res_ready_o !== 1'b0 || btb_upd_valid_o !== 1'b1 || btb_upd_del_o !== 1'b0) begin failures++;
      $display("FAIL fill_pop_full got=%0b/%0b/%0b exp=0/1/0", bu_res_ready_o, btb_upd_valid_o, btb_upd_del_o); end
    exp_ghr = {exp_ghr[HL-2:0], 1'b1};
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk_i);
      if (i == 1) begin
        checks++; if (bu_res_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready_rise got=%0b exp=1", bu_res_ready_o); end
      end
      checks++; if (pht_upd_valid_o !== 1'b1 || pht_upd_pc_o !== ent[i].pc || pht_upd_taken_o !== ent[i].taken ||
                    btb_upd_valid_o !== ent[i].taken) begin failures++;
        $display("FAIL fill_retire%0d got=%0b/%h/%0b/%0b exp=1/%h/%0b/%0b", i, pht_upd_valid_o, pht_upd_pc_o,
                 pht_upd_taken_o, btb_upd_valid_o, ent[i].pc, ent[i].taken, ent[i].taken); end
      exp_ghr = {exp_ghr[HL-2:0], ent[i].taken};
      next_cycle();
    end
    @(negedge clk_i);
    checks++; if (pht_upd_valid_o !== 1'b0 || ghr_o !== exp_ghr) begin failures++;
      $display("FAIL fill_drained got=%0b/%h exp=0/%h", pht_upd_valid_o, ghr_o, exp_ghr); end
    next_cycle();
  endtask

  task automatic test_taken_target();
    drive(1'b1, mk(32'h7fff_fff0, 32'h8000_0010, 1'b1, 1'b1), 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    next_cycle();
    @(negedge clk_i);
    checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0010 || btb_upd_del_o !== 1'b0 ||
                  ghr_restore_valid_o !== 1'b1) begin failures++;
      $display("FAIL taken_target got=%0b/%h/%0b/%0b exp=1/80000010/0/1", redirect_valid_o, redirect_pc_o,
               btb_upd_del_o, ghr_restore_valid_o); end
    exp_ghr = {exp_ghr[HL-2:0], 1'b1};
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++; if (ghr_o !== exp_ghr) begin failures++; $display("FAIL taken_ghr got=%h exp=%h", ghr_o, exp_ghr); end
    next_cycle();
  endtask

  task automatic test_flush();
    drive(1'b1, mk(32'hA00, 32'hB00, 1'b0, 1'b1), 1'b0, 1'b0); next_cycle();
    drive(1'b1, mk(32'hA10, 32'hB10, 1'b1, 1'b0), 1'b0, 1'b0); next_cycle();
    drive(1'b1, mk(32'hA20, 32'hB20, 1'b1, 1'b0), 1'b0, 1'b0); next_cycle();
    drive(1'b1, mk(32'hA30, 32'hB30, 1'b1, 1'b0), 1'b1, 1'b1);
    @(negedge clk_i);
    checks++; if (redirect_valid_o !== 1'b1 || pht_upd_valid_o !== 1'b0 || btb_upd_valid_o !== 1'b0 ||
                  ghr_restore_valid_o !== 1'b0) begin failures++;
      $display("FAIL flush_cycle got=%0b/%0b/%0b/%0b exp=1/0/0/0", redirect_valid_o, pht_upd_valid_o,
               btb_upd_valid_o, ghr_restore_valid_o); end
    next_cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++; if (redirect_valid_o !== 1'b0 || pht_upd_valid_o !== 1'b0 || bu_res_ready_o !== 1'b1 ||
                    ghr_o !== exp_ghr || dbg_state_o !== BRH_IDLE) begin failures++;
        $display("FAIL flush_after%0d got=%0b/%0b/%0b/%h/%0d exp=0/0/1/%h/%0d", i, redirect_valid_o, pht_upd_valid_o,
                 bu_res_ready_o, ghr_o, dbg_state_o, exp_ghr, BRH_IDLE); end
      next_cycle();
    end
  endtask

  // Reference model: ordered queue of accepted resolutions, a pending-redirect
  // flag and the committed history, advanced once per clock.
  task automatic test_random();
    resolution_t mq[$];
    bit          m_pend = 1'b0;
    logic [HL-1:0] m_ghr = exp_ghr;
    for (int c = 0; c < 600; c++) begin
      logic v, rdy, fl, e_ready, e_pht, e_btb, e_del, e_rst, e_pop;
      resolution_t r, h;
      logic [XLEN-1:0] e_rpc;
      v   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 39) == 0);
      r   = mk({$urandom_range(0, 32'hFFFF), 2'b00}, {$urandom_range(0, 32'hFFFF), 2'b00},
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      drive(v, r, rdy, fl);
      @(negedge clk_i);
      h = (mq.size() > 0) ? mq[0] : '0;
      e_ready = (mq.size() < DEPTH);
      e_pht = 0; e_btb = 0; e_del = 0; e_rst = 0; e_pop = 0;
      if (mq.size() > 0) begin
        if (m_pend) begin
          if (rdy) begin e_pop = 1; e_pht = 1; e_btb = 1; e_del = !h.taken; e_rst = 1; end
        end else if (!h.mispredict) begin
          e_pop = 1; e_pht = 1; e_btb = h.taken;
        end
      end
      if (fl) begin e_pop = 0; e_pht = 0; e_btb = 0; e_rst = 0; end
      e_rpc = h.taken ? h.target : h.pc + 32'd4;
      checks++; if (bu_res_ready_o !== e_ready || redirect_valid_o !== m_pend || pht_upd_valid_o !== e_pht ||
                    btb_upd_valid_o !== e_btb || ghr_restore_valid_o !== e_rst || ghr_o !== m_ghr) begin failures++;
        $display("FAIL rand_ctrl c=%0d got=%0b%0b%0b%0b%0b/%h exp=%0b%0b%0b%0b%0b/%h", c, bu_res_ready_o, redirect_valid_o,
                 pht_upd_valid_o, btb_upd_valid_o, ghr_restore_valid_o, ghr_o, e_ready, m_pend, e_pht, e_btb, e_rst, m_ghr); end
      if (m_pend) begin
        checks++; if (redirect_pc_o !== e_rpc) begin failures++;
          $display("FAIL rand_rpc c=%0d got=%h exp=%h", c, redirect_pc_o, e_rpc); end
      end
      if (e_pht) begin
        checks++; if (pht_upd_pc_o !== h.pc || pht_upd_taken_o !== h.taken) begin failures++;
          $display("FAIL rand_pht c=%0d got=%h/%0b exp=%h/%0b", c, pht_upd_pc_o, pht_upd_taken_o, h.pc, h.taken); end
      end
      if (e_btb) begin
        checks++; if (btb_upd_pc_o !== h.pc || btb_upd_target_o !== h.target || btb_upd_del_o !== e_del) begin failures++;
          $display("FAIL rand_btb c=%0d got=%h/%h/%0b exp=%h/%h/%0b", c, btb_upd_pc_o, btb_upd_target_o,
                   btb_upd_del_o, h.pc, h.target, e_del); end
      end
      if (fl) begin
        mq.delete();
        m_pend = 1'b0;
      end else begin
        if (e_pop) begin
          m_ghr = {m_ghr[HL-2:0], h.taken};
          void'(mq.pop_front());
          m_pend = 1'b0;
        end else if (!m_pend && mq.size() > 0 && h.mispredict) begin
          m_pend = 1'b1;
        end
        if (v && e_ready) mq.push_back(r);
      end
      next_cycle();
    end
    exp_ghr = m_ghr;
  endtask

  task automatic test_async_reset();
    drive(1'b0, '0, 1'b0, 1'b1); next_cycle();
    drive(1'b1, mk(32'hC00, 32'hD00, 1'b1, 1'b1), 1'b0, 1'b0); next_cycle();
    drive(1'b1, mk(32'hC10, 32'hD10, 1'b1, 1'b0), 1'b0, 1'b0); next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0); next_cycle();
    #2 rst_n_i = 1'b0;
    #1;
    checks++; if (redirect_valid_o !== 1'b0 || ghr_o !== 8'h00 || bu_res_ready_o !== 1'b1 ||
                  pht_upd_valid_o !== 1'b0 || dbg_state_o !== BRH_IDLE) begin failures++;
      $display("FAIL async_reset got=%0b/%h/%0b/%0b/%0d exp=0/00/1/0/%0d", redirect_valid_o, ghr_o,
               bu_res_ready_o, pht_upd_valid_o, dbg_state_o, BRH_IDLE); end
    next_cycle();
    rst_n_i = 1'b1;
    exp_ghr = '0;
    @(negedge clk_i);
    checks++; if (redirect_valid_o !== 1'b0 || pht_upd_valid_o !== 1'b0) begin failures++;
      $display("FAIL async_after got=%0b/%0b exp=0/0", redirect_valid_o, pht_upd_valid_o); end
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    apply_reset();
    test_reset();
    test_basic();
    test_mispredict_stall();
    test_fill_full();
    test_taken_target();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing the test sequence");
    $fatal(1, "timeout");
  end

endmodule
